// File: rtl/led_frame_scheduler_if.sv
// Pixel-memory read port and encoder handshake shared by the scheduler
// (master side) and the memory/encoder it drives (slave side).
interface led_frame_scheduler_if #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 6
);
    logic [ADDR_WIDTH-1:0] pixel_addr;
    logic                  pixel_read;
    logic [DATA_WIDTH-1:0] pixel_data;
    logic [DATA_WIDTH-1:0] encoder_data;
    logic                  encoder_enable;
    logic                  encoder_ready;

    modport master (
        output pixel_addr, pixel_read, encoder_data, encoder_enable,
        input  pixel_data, encoder_ready
    );

    modport slave (
        input  pixel_addr, pixel_read, encoder_data, encoder_enable,
        output pixel_data, encoder_ready
    );
endinterface

// File: rtl/led_frame_scheduler.sv
// Frame sequencer: reads LED_COUNT words from pixel memory and hands them to
// the RZ line encoder back to back, then waits out the latch gap and pulses
// frame_done. Frames start on request, on a queued request, or on the
// optional refresh timer.
module led_frame_scheduler #(
    parameter int DATA_WIDTH     = 24,
    parameter int LED_COUNT      = 64,
    parameter int ADDR_WIDTH     = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1,
    parameter int REFRESH_CYCLES = 0
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 frame_start,
    input  logic                 blank,
    output logic                 busy,
    output logic                 frame_done,
    led_frame_scheduler_if.master bus
);
    localparam int RW = (REFRESH_CYCLES > 0) ? $clog2(REFRESH_CYCLES + 1) : 1;
    localparam logic [RW-1:0] REFRESH_INIT = RW'(REFRESH_CYCLES);
    // The begin cycle also counts as an elapsed cycle, so reloading with one
    // less gives a start-to-start period of exactly REFRESH_CYCLES.
    localparam logic [RW-1:0] REFRESH_RELOAD = RW'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(LED_COUNT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        OFFER = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic [RW-1:0]         refresh_q, refresh_d;
    logic                  blank_q, blank_d;
    logic                  pending_q, pending_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  read_q, read_d;
    logic                  enable_q, enable_d;
    logic                  ready_seen_q, ready_seen_d;
    logic                  refresh_hit;
    logic                  request;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            index_q      <= '0;
            addr_q       <= '0;
            hold_q       <= '0;
            refresh_q    <= REFRESH_INIT;
            blank_q      <= 1'b0;
            pending_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            read_q       <= 1'b0;
            enable_q     <= 1'b0;
            ready_seen_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            addr_q       <= addr_d;
            hold_q       <= hold_d;
            refresh_q    <= refresh_d;
            blank_q      <= blank_d;
            pending_q    <= pending_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            read_q       <= read_d;
            enable_q     <= enable_d;
            ready_seen_q <= ready_seen_d;
        end
    end

    // Next-state logic: frame sequencing, request queueing, refresh timer.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        addr_d       = addr_q;
        hold_d       = hold_q;
        blank_d      = blank_q;
        pending_d    = pending_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        read_d       = 1'b0;
        enable_d     = enable_q;
        ready_seen_d = ready_seen_q;
        refresh_d    = (refresh_q != '0) ? refresh_q - RW'(1) : refresh_q;
        refresh_hit  = (REFRESH_CYCLES > 0) && (refresh_q == '0);
        request      = frame_start || refresh_hit;

        // busy_q also covers the frame_done cycle, so a request then is queued.
        if (busy_q && request) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (busy_q) begin
                    // frame_done cycle: release busy, start nothing yet.
                    busy_d = 1'b0;
                end else if (request || pending_q) begin
                    blank_d   = blank;
                    index_d   = '0;
                    busy_d    = 1'b1;
                    pending_d = 1'b0;
                    refresh_d = REFRESH_RELOAD;
                    if (blank) begin
                        state_d = LOAD;
                    end else begin
                        state_d = FETCH;
                        read_d  = 1'b1;
                        addr_d  = '0;
                    end
                end
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                hold_d   = blank_q ? '0 : bus.pixel_data;
                enable_d = 1'b1;
                state_d  = OFFER;
            end
            OFFER: begin
                if (enable_q && bus.encoder_ready) begin
                    enable_d = 1'b0;
                    if (index_q == LAST_INDEX) begin
                        state_d      = DRAIN;
                        ready_seen_d = 1'b0;
                    end else begin
                        index_d = index_q + ADDR_WIDTH'(1);
                        if (blank_q) begin
                            state_d = LOAD;
                        end else begin
                            state_d = FETCH;
                            read_d  = 1'b1;
                            addr_d  = index_q + ADDR_WIDTH'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                // Only two consecutive ready cycles mark the end of the latch gap.
                ready_seen_d = bus.encoder_ready;
                if (bus.encoder_ready && ready_seen_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy               = busy_q;
    assign frame_done         = done_q;
    assign bus.pixel_addr     = addr_q;
    assign bus.pixel_read     = read_q;
    assign bus.encoder_data   = hold_q;
    assign bus.encoder_enable = enable_q;
endmodule

// File: tb/tb_led_frame_scheduler.sv
// Scoreboard bench: instance A (3 LEDs, no refresh) covers data order,
// back-pressure, drain qualification and request queueing; instance B
// (4 LEDs, 2000-cycle refresh) covers blank frames, auto refresh and reset.
module tb_led_frame_scheduler;
    localparam int DW   = 24;
    localparam int LC_A = 3;
    localparam int LC_B = 4;
    localparam int AW   = 2;
    localparam int RC_B = 2000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n_a, rst_n_b, start_a, start_b, blank_a, blank_b;
    logic busy_a, busy_b, done_a, done_b;

    led_frame_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_a ();
    led_frame_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();

    led_frame_scheduler #(.DATA_WIDTH(DW), .LED_COUNT(LC_A), .ADDR_WIDTH(AW), .REFRESH_CYCLES(0)) u_dut_a (
        .clock(clk), .reset_n(rst_n_a), .frame_start(start_a), .blank(blank_a),
        .busy(busy_a), .frame_done(done_a), .bus(bus_a)
    );

    led_frame_scheduler #(.DATA_WIDTH(DW), .LED_COUNT(LC_B), .ADDR_WIDTH(AW), .REFRESH_CYCLES(RC_B)) u_dut_b (
        .clock(clk), .reset_n(rst_n_b), .frame_start(start_b), .blank(blank_b),
        .busy(busy_b), .frame_done(done_b), .bus(bus_b)
    );

    logic [DW-1:0] mem_a [LC_A];
    logic [DW-1:0] mem_b [LC_B];

    // Pixel memories: data valid the cycle after the read strobe.
    always @(posedge clk) if (bus_a.pixel_read) bus_a.pixel_data <= mem_a[bus_a.pixel_addr];
    always @(posedge clk) if (bus_b.pixel_read) bus_b.pixel_data <= mem_b[bus_b.pixel_addr];

    int n_compared = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_word_a[$];
    logic [31:0] exp_addr_a[$];
    logic [31:0] exp_word_b[$];
    logic [31:0] exp_addr_b[$];
    int xfer_a = 0;
    int xfer_b = 0;

    // Monitors: every read and every transfer is checked against the scoreboard.
    always @(negedge clk) begin
        if (bus_a.pixel_read) begin
            if (exp_addr_a.size() == 0) check("a_unexpected_read", 1, 0);
            else check("a_read_addr", 32'(bus_a.pixel_addr), exp_addr_a.pop_front());
        end
        if (bus_a.encoder_enable && bus_a.encoder_ready) begin
            xfer_a++;
            if (exp_word_a.size() == 0) check("a_unexpected_xfer", 1, 0);
            else check("a_word", 32'(bus_a.encoder_data), exp_word_a.pop_front());
        end
    end

    always @(negedge clk) begin
        if (bus_b.pixel_read) begin
            if (exp_addr_b.size() == 0) check("b_unexpected_read", 1, 0);
            else check("b_read_addr", 32'(bus_b.pixel_addr), exp_addr_b.pop_front());
        end
        if (bus_b.encoder_enable && bus_b.encoder_ready) begin
            xfer_b++;
            if (exp_word_b.size() == 0) check("b_unexpected_xfer", 1, 0);
            else check("b_word", 32'(bus_b.encoder_data), exp_word_b.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a();
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    task automatic pulse_b();
        start_b = 1'b1;
        step();
        start_b = 1'b0;
    endtask

    task automatic push_frame_a();
        for (int i = 0; i < LC_A; i++) begin
            exp_word_a.push_back(32'(mem_a[i]));
            exp_addr_a.push_back(32'(i));
        end
    endtask

    task automatic push_frame_b(input bit blank_frame);
        for (int i = 0; i < LC_B; i++) begin
            exp_word_b.push_back(blank_frame ? 32'd0 : 32'(mem_b[i]));
            if (!blank_frame) exp_addr_b.push_back(32'(i));
        end
    endtask

    task automatic wait_done_a(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_a) begin seen = 1'b1; break; end
        end
        check({tag, "_done"}, 32'(seen), 1);
        if (seen) check({tag, "_busy_at_done"}, 32'(busy_a), 1);
    endtask

    task automatic wait_done_b(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_b) begin seen = 1'b1; break; end
        end
        check({tag, "_done"}, 32'(seen), 1);
    endtask

    task automatic wait_read0_b(input string tag, output int at);
        bit seen = 1'b0;
        at = 0;
        for (int i = 0; i < RC_B + 100; i++) begin
            @(negedge clk);
            if (bus_b.pixel_read && bus_b.pixel_addr == '0) begin seen = 1'b1; at = cyc; break; end
        end
        check({tag, "_start_seen"}, 32'(seen), 1);
    endtask

    task automatic seq_a();
        int cnt;
        int k;
        bit ok;
        logic [DW-1:0] d0;

        // Frame with immediate accept: order, latency, single done, busy release.
        step();
        bus_a.encoder_ready = 1'b1;
        push_frame_a();
        pulse_a();
        @(negedge clk);
        check("a_t1_read", 32'(bus_a.pixel_read), 1);
        check("a_t1_busy", 32'(busy_a), 1);
        @(negedge clk);
        check("a_t2_enable", 32'(bus_a.encoder_enable), 0);
        @(negedge clk);
        check("a_t3_enable", 32'(bus_a.encoder_enable), 1);
        wait_done_a("a_basic");
        step();
        check("a_basic_busy_after", 32'(busy_a), 0);
        check("a_basic_xfers", 32'(xfer_a), 3);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clk); if (done_a) cnt++; end
        check("a_basic_single_done", 32'(cnt), 0);
        check("a_basic_queue_empty", 32'(exp_word_a.size()), 0);

        // Back-pressure: word held stable for 50 cycles of ready low.
        step();
        bus_a.encoder_ready = 1'b0;
        push_frame_a();
        pulse_a();
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus_a.encoder_enable) begin ok = 1'b1; break; end
        end
        check("a_hold_enable_seen", 32'(ok), 1);
        d0 = bus_a.encoder_data;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!bus_a.encoder_enable || bus_a.encoder_data !== d0) cnt++;
        end
        check("a_hold_stable", 32'(cnt), 0);
        check("a_hold_word", 32'(d0), 32'(mem_a[0]));
        step();
        bus_a.encoder_ready = 1'b1;
        @(negedge clk);
        check("a_hold_xfer_enable", 32'(bus_a.encoder_enable), 1);
        step();
        @(negedge clk);
        check("a_hold_enable_drop", 32'(bus_a.encoder_enable), 0);
        wait_done_a("a_hold");

        // Drain: a lone ready pulse must not finish the frame.
        step();
        push_frame_a();
        pulse_a();
        k = 0;
        for (int i = 0; i < 60 && k < 3; i++) begin
            @(negedge clk);
            if (bus_a.encoder_enable && bus_a.encoder_ready) k++;
        end
        check("a_drain_xfers", 32'(k), 3);
        step();
        bus_a.encoder_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin @(negedge clk); if (done_a) cnt++; step(); end
        bus_a.encoder_ready = 1'b1;
        @(negedge clk); if (done_a) cnt++;
        step();
        bus_a.encoder_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin @(negedge clk); if (done_a) cnt++; step(); end
        check("a_drain_single_pulse", 32'(cnt), 0);
        bus_a.encoder_ready = 1'b1;
        @(negedge clk);
        check("a_drain_h1", 32'(done_a), 0);
        step();
        @(negedge clk);
        check("a_drain_h2", 32'(done_a), 0);
        step();
        @(negedge clk);
        check("a_drain_h3_done", 32'(done_a), 1);
        check("a_drain_h3_busy", 32'(busy_a), 1);
        step();
        @(negedge clk);
        check("a_drain_h4_done", 32'(done_a), 0);
        check("a_drain_h4_busy", 32'(busy_a), 0);

        // Two requests while busy: exactly one queued frame, after a one-cycle gap.
        step();
        push_frame_a();
        push_frame_a();
        pulse_a();
        step();
        step();
        pulse_a();
        step();
        step();
        pulse_a();
        wait_done_a("a_pend_first");
        step();
        @(negedge clk);
        check("a_pend_gap_busy", 32'(busy_a), 0);
        check("a_pend_gap_read", 32'(bus_a.pixel_read), 0);
        step();
        @(negedge clk);
        check("a_pend_start_read", 32'(bus_a.pixel_read), 1);
        check("a_pend_start_busy", 32'(busy_a), 1);
        wait_done_a("a_pend_second");
        cnt = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (done_a || busy_a) cnt++; end
        check("a_pend_no_third", 32'(cnt), 0);
        check("a_pend_queue_empty", 32'(exp_word_a.size()), 0);
    endtask

    task automatic seq_b();
        int t0;
        int r1;
        int r2;
        int r3;
        int k;
        bit ok;

        // Blank frame: no reads, zero words, enable two cycles after start.
        step();
        bus_b.encoder_ready = 1'b1;
        blank_b = 1'b1;
        push_frame_b(1'b1);
        t0 = cyc;
        pulse_b();
        blank_b = 1'b0;
        @(negedge clk);
        check("b_blank_t1_read", 32'(bus_b.pixel_read), 0);
        check("b_blank_t1_enable", 32'(bus_b.encoder_enable), 0);
        @(negedge clk);
        check("b_blank_t2_enable", 32'(bus_b.encoder_enable), 1);
        wait_done_b("b_blank");
        step();
        check("b_blank_xfers", 32'(xfer_b), 4);
        check("b_blank_busy_after", 32'(busy_b), 0);

        // Auto refresh: starts exactly RC_B cycles apart.
        push_frame_b(1'b0);
        push_frame_b(1'b0);
        wait_read0_b("b_refresh1", r1);
        check("b_refresh1_period", 32'(r1 - (t0 + 1)), RC_B);
        wait_done_b("b_refresh1");
        wait_read0_b("b_refresh2", r2);
        check("b_refresh2_period", 32'(r2 - r1), RC_B);
        wait_done_b("b_refresh2");

        // Third refresh frame: stall on word 2, then reset mid-offer.
        step();
        push_frame_b(1'b0);
        wait_read0_b("b_refresh3", r3);
        check("b_refresh3_period", 32'(r3 - r2), RC_B);
        k = 0;
        for (int i = 0; i < 40 && k < 2; i++) begin
            @(negedge clk);
            if (bus_b.encoder_enable && bus_b.encoder_ready) k++;
        end
        check("b_rst_xfers_before", 32'(k), 2);
        step();
        bus_b.encoder_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus_b.encoder_enable) begin ok = 1'b1; break; end
        end
        check("b_rst_offer_reached", 32'(ok), 1);
        check("b_rst_addr_before", 32'(bus_b.pixel_addr), 2);
        @(posedge clk);
        #3;
        rst_n_b = 1'b0;
        #1;
        check("b_rst_enable", 32'(bus_b.encoder_enable), 0);
        check("b_rst_data", 32'(bus_b.encoder_data), 0);
        check("b_rst_read", 32'(bus_b.pixel_read), 0);
        check("b_rst_addr", 32'(bus_b.pixel_addr), 0);
        check("b_rst_busy", 32'(busy_b), 0);
        check("b_rst_done", 32'(done_b), 0);
        exp_word_b.delete();
        exp_addr_b.delete();
        step();
        rst_n_b = 1'b1;
        bus_b.encoder_ready = 1'b1;
        step();
        push_frame_b(1'b0);
        pulse_b();
        @(negedge clk);
        check("b_after_rst_read", 32'(bus_b.pixel_read), 1);
        check("b_after_rst_addr", 32'(bus_b.pixel_addr), 0);
        wait_done_b("b_after_rst");
        step();
        check("b_after_rst_queue_empty", 32'(exp_word_b.size()), 0);
    endtask

    initial begin
        logic [31:0] tmp;
        mem_a[0] = 24'hFF0000;
        mem_a[1] = 24'h00FF00;
        mem_a[2] = 24'h0000FF;
        for (int i = 0; i < LC_B; i++) begin
            tmp = $urandom;
            mem_b[i] = tmp[23:0] | 24'h000001;
        end
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        blank_a = 1'b0;
        blank_b = 1'b0;
        bus_a.encoder_ready = 1'b0;
        bus_b.encoder_ready = 1'b0;
        step();
        step();
        @(negedge clk);
        check("a_reset_busy", 32'(busy_a), 0);
        check("a_reset_done", 32'(done_a), 0);
        check("a_reset_read", 32'(bus_a.pixel_read), 0);
        check("a_reset_addr", 32'(bus_a.pixel_addr), 0);
        check("a_reset_enable", 32'(bus_a.encoder_enable), 0);
        check("a_reset_data", 32'(bus_a.encoder_data), 0);
        check("b_reset_busy", 32'(busy_b), 0);
        step();
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        fork
            seq_a();
            seq_b();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/led_frame_scheduler.md
# led_frame_scheduler

Frame-level sequencer for the unipolar return-to-zero LED line encoder. It fetches LED_COUNT pixel words from a single-port pixel memory and presents them to the encoder through its data/enable/ready handshake, back to back, so that a full strip frame goes out without gaps. It then waits for the encoder's latch/reset gap to finish and reports frame completion. It sits between the frame-buffer/pixel memory and the encoder instance, and can be triggered manually or by an internal refresh timer.

## Interface
- DATA_WIDTH, 24: pixel word width; equals the encoder's DATA_WIDTH.
- LED_COUNT, 64: words per frame, ≥1.
- ADDR_WIDTH, $clog2(LED_COUNT) (min 1): pixel memory address width.
- REFRESH_CYCLES, 0: auto-refresh period in clock cycles; 0 disables auto-refresh.
- clock  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  single-cycle request to send one frame.
- blank  in  1  sampled at frame start; 1 = send all-zero words, no memory reads.
- busy  out  1  high from frame start until frame_done inclusive.
- frame_done  out  1  one-cycle pulse when the frame, including the latch gap, is complete.
- pixel_addr  out  ADDR_WIDTH  registered read address.
- pixel_read  out  1  read strobe, one cycle per word.
- pixel_data  in  DATA_WIDTH  valid exactly 1 cycle after pixel_read.
- encoder_data  out  DATA_WIDTH  word offered to the encoder; driven from the holding register.
- encoder_enable  out  1  registered; high while a word is offered.
- encoder_ready  in  1  encoder ready.

## Operation
- Reset values: busy=0, frame_done=0, pixel_read=0, pixel_addr=0, encoder_enable=0, encoder_data=0, word index=0, pending=0, refresh counter=REFRESH_CYCLES, state IDLE.
- States:
  - IDLE: a frame begins on frame_start, pending=1, or refresh counter==0 (REFRESH_CYCLES>0). On begin: latch blank, index=0, busy=1, clear pending, reload refresh counter. Go to FETCH, or to LOAD if blank.
  - FETCH: pixel_read=1, pixel_addr=index. Go to LOAD.
  - LOAD: holding register <= pixel_data, or 0 if blank. Next cycle encoder_enable=1. Go to OFFER.
  - OFFER: a transfer completes on a cycle with encoder_enable && encoder_ready. On transfer, encoder_enable<=0.
    - If index==LED_COUNT-1: go to DRAIN.
    - Otherwise index+1, then FETCH, or LOAD if blank.
  - DRAIN: encoder_enable=0. Wait for encoder_ready high on 2 consecutive cycles. A single-cycle ready in the encoder's last-bit phase does not count. Then frame_done pulses for 1 cycle and the block returns to IDLE. busy drops the cycle after frame_done.
- encoder_enable must never depend combinationally on encoder_ready. It is a flop.
- Holding register and encoder_data are stable while encoder_enable=1.
- frame_start while busy sets pending (one deep; extra requests are dropped). The pending frame starts in the first IDLE cycle after frame_done.
- Refresh counter decrements every cycle in every state, saturating at 0. A refresh expiry during a frame also sets pending.
- frame_start and refresh expiry in the same IDLE cycle start one frame only.
- blank changes mid-frame are ignored.
- reset_n low mid-frame: all state returns to reset values asynchronously. The encoder may be mid-word; the frame is not resumed.

## Timing
- frame_start in IDLE at cycle T: pixel_read=1 at T+1, holding register loaded at T+2, encoder_enable=1 at T+3.
  - With blank: encoder_enable=1 at T+2.
- Transfer at cycle A: next word's encoder_enable=1 at A+3 (A+2 blank). This fits within one encoder word time for any DATA_WIDTH≥1, so the encoder chains words without a reset gap.
- Exactly LED_COUNT pixel_read pulses per non-blank frame, at addresses 0..LED_COUNT-1 in order. A blank frame has zero reads.
- frame_done is 1 cycle after the second consecutive encoder_ready-high cycle in DRAIN.

## Test plan
- LED_COUNT=3, memory holds 0xFF0000, 0x00FF00, 0x0000FF; pulse frame_start; encoder model accepts at once -> reads at addresses 0, 1, 2; encoder_data matches in order; 3 transfers; frame_done once; busy low after.
- Encoder model holds ready low 50 cycles while encoder_enable=1 -> encoder_data and encoder_enable stable throughout; transfer on the first ready-high cycle.
- blank=1 at frame_start, LED_COUNT=4 -> no pixel_read; 4 transfers of 0x000000.
- In DRAIN, ready pulses 1 cycle, then low 10 cycles, then high -> no frame_done on the single pulse; frame_done one cycle after the second consecutive high cycle.
- frame_start twice during a busy frame, REFRESH_CYCLES=0 -> exactly one extra frame, starting the IDLE cycle after frame_done.
- REFRESH_CYCLES=2000 -> frames start every 2000 cycles; reset_n asserted mid-OFFER -> all outputs at reset values immediately; the next frame begins at address 0.
